// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, frame lengths and FSM states for the conv stream feeder (GAP state only with CONV_FEEDER_GAP_EN)
package conv_pkg;
  localparam int DATA_W      = 16;
  localparam int IMG_N       = 7;
  localparam int K_N         = 3;
  localparam int FRAME_LEN_K = 90;
  localparam int FRAME_LEN   = 81;
  typedef enum logic [2:0] {
    IDLE,
    KERN,
    FIRST,
    ROW,
    SWEEP
`ifdef CONV_FEEDER_GAP_EN
    , GAP
`endif
  } state_t;
endpackage

// File: rtl/conv_scan_addr.sv
// conv_scan_addr: row/column generator for the serpentine kernel-window scan order
module conv_scan_addr import conv_pkg::*; #(
  parameter int IMG_N = conv_pkg::IMG_N,
  parameter int K_N   = conv_pkg::K_N
) (
  input  logic       clk,
  input  logic       rst_n,
  input  state_t     state,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       phase_last
);
  localparam int SW_N = IMG_N - K_N;
  logic [1:0] a_q, a_d, b_q, b_d;
  logic [2:0] w_q, w_d;
  logic       scan;
  // a = major step (column or kernel row), b = minor step inside a triplet, w = window row
  always_comb begin
    scan       = state inside {KERN, FIRST, ROW, SWEEP};
    phase_last = scan && b_q == 2'(K_N-1) &&
                 (state == ROW || (state == SWEEP ? a_q == 2'(SW_N-1) : a_q == 2'(K_N-1)));
    a_d = !scan || phase_last ? 2'd0 : b_q == 2'(K_N-1) ? a_q + 2'd1 : a_q;
    b_d = !scan || b_q == 2'(K_N-1) ? 2'd0 : b_q + 2'd1;
    w_d = !scan ? 3'd1 : state == SWEEP && phase_last && w_q != 3'(SW_N+1) ? w_q + 3'd1 : w_q;
    row = state == KERN  ? 3'(a_q) + 3'd1 :
          state == FIRST ? 3'(b_q) + 3'd1 :
          state == ROW   ? w_q + 3'(K_N-1) : w_q + 3'(b_q);
    col = state == KERN  ? 3'(b_q) + 3'd1 :
          state == FIRST ? 3'(a_q) + 3'd1 :
          state == ROW   ? (w_q[0] ? 3'd1 : 3'(SW_N+1)) + 3'(b_q) :
          w_q[0] ? 3'(K_N+1) + 3'(a_q) : 3'(K_N+1) - 3'(a_q);
  end
  // scan counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q <= 2'd0;
      b_q <= 2'd0;
      w_q <= 3'd1;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      w_q <= w_d;
    end
endmodule

// File: rtl/conv_stream_feeder.sv
// conv_stream_feeder: reads kernel/pixel memory in conv scan order and streams words to the conv core (CONV_FEEDER_GAP_EN adds an inter-frame gap)
module conv_stream_feeder import conv_pkg::*; #(
  parameter int DATA_W     = conv_pkg::DATA_W,
  parameter int IMG_N      = conv_pkg::IMG_N,
  parameter int K_N        = conv_pkg::K_N,
  parameter int GAP_CYCLES = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              load_kernel,
  output logic              rd_en,
  output logic              rd_sel,
  output logic [2:0]        rd_row,
  output logic [2:0]        rd_col,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] data,
  output logic              ena,
  output logic              busy,
  output logic              done
);
  state_t            state_q, state_d;
  logic              kern_q, kern_d, ena_q, done_q, phase_last, frame_last;
  logic [6:0]        cnt_q, cnt_d;
  logic [2:0]        row, col;
  logic [DATA_W-1:0] hold_q;
  conv_scan_addr #(.IMG_N(IMG_N), .K_N(K_N)) u_scan (
    .clk(clk), .rst_n(rst_n), .state(state_q), .row(row), .col(col), .phase_last(phase_last)
  );
`ifdef CONV_FEEDER_GAP_EN
  logic [7:0] gap_q;
  // gap state lasts GAP_CYCLES-1 cycles; the IDLE cycle that follows completes the ena-low window
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) gap_q <= 8'd0;
    else        gap_q <= state_q == GAP ? gap_q + 8'd1 : 8'd0;
`else
  logic unused_gap;
  assign unused_gap = ^GAP_CYCLES;
`endif
  // read strobe/address decode, frame length tracking and next state
  always_comb begin
    rd_en      = state_q inside {KERN, FIRST, ROW, SWEEP};
    rd_sel     = rd_en && state_q != KERN;
    rd_row     = rd_en ? row : 3'd0;
    rd_col     = rd_en ? col : 3'd0;
    frame_last = rd_en && cnt_q == 7'(kern_q ? FRAME_LEN_K-1 : FRAME_LEN-1);
    kern_d     = state_q == IDLE && start ? load_kernel : kern_q;
    cnt_d      = rd_en ? cnt_q + 7'd1 : 7'd0;
    state_d    = frame_last ?
`ifdef CONV_FEEDER_GAP_EN
                 GAP :
`else
                 IDLE :
`endif
                 state_q == IDLE ? (start ? (load_kernel ? KERN : FIRST) : IDLE) :
                 phase_last ? (state_q == KERN ? FIRST : state_q == SWEEP ? ROW : SWEEP) : state_q;
`ifdef CONV_FEEDER_GAP_EN
    if (state_q == GAP) state_d = gap_q == 8'(GAP_CYCLES-2) ? IDLE : GAP;
`endif
    data = ena_q ? rd_data : hold_q;
    ena  = ena_q;
    busy = rd_en | ena_q;
    done = done_q;
  end
  // FSM state, frame bookkeeping and output register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      kern_q  <= 1'b0;
      cnt_q   <= 7'd0;
      ena_q   <= 1'b0;
      done_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      kern_q  <= kern_d;
      cnt_q   <= cnt_d;
      ena_q   <= rd_en;
      done_q  <= frame_last;
      hold_q  <= data;
    end
endmodule
